pixel_scan_sequencer: RTL and testbench

//  Frame-level scheduler for the pixel-processing datapath. On start, walks every

---
 rtl/pixel_scan_sequencer.sv | 150 +++++++++++++++
 tb/tb_pixel_scan_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_sequencer.sv
// Frame scheduler: per pixel READ -> WAIT(RD_LAT) -> PROC(until proc_done) -> WRITE, then FINISH.
// Optional macro PIX_SEQ_PERF_EN adds the perf_cycles busy-cycle counter output.
module pixel_scan_sequencer #(
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned DST_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              proc_en,
  input  logic              proc_done,
  output logic              wren,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
`ifdef PIX_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int unsigned       NPIX     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DST_BASE);
  localparam int unsigned       CNT_W    = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PROC,
    S_WRITE,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               rd_en_q, proc_en_q, wren_q, busy_q, done_q;
  logic               rd_en_d, proc_en_d, wren_d, busy_d, done_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      S_IDLE:   if (start && !abort) state_d = S_READ;
      S_READ: begin
        state_d = S_WAIT;
        lat_d   = CNT_W'(RD_LAT);
      end
      S_WAIT: begin
        if (lat_q == CNT_W'(1)) state_d = S_PROC;
        else                    lat_d   = lat_q - CNT_W'(1);
      end
      S_PROC:   if (proc_done) state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default:  state_d = S_IDLE;
    endcase
    // abort overrides every transition above, including end-of-frame
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end
    // outputs are registered from the next state so they reflect state_q after the edge
    if (state_d == S_READ)  rd_addr_d = idx_d;
    if (state_d == S_WRITE) wr_addr_d = BASE + idx_d;
    rd_en_d   = (state_d == S_READ);
    proc_en_d = (state_d == S_PROC);
    wren_d    = (state_d == S_WRITE);
    done_d    = (state_d == S_FINISH);
    busy_d    = (state_d != S_IDLE);
  end

`ifdef PIX_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (state_d == S_READ) perf_d = '0;
    end else if (perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lat_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      proc_en_q <= 1'b0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_en_q   <= rd_en_d;
      proc_en_q <= proc_en_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign proc_en = proc_en_q;
  assign wren    = wren_q;
  assign wr_addr = wr_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench for pixel_scan_sequencer: 4x2 frame, RD_LAT=2 (dut_a) and
// RD_LAT=1 with wrapping destination base (dut_b).
module tb_pixel_scan_sequencer;
  localparam int unsigned AW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, abort, proc_done;
  logic          rd_en, proc_en, wren, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          start_b, abort_b;
  logic          rd_en_b, proc_en_b, wren_b, busy_b, done_b;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
`ifdef PIX_SEQ_PERF_EN
  logic [31:0]   perf_cycles, perf_cycles_b;
`endif

  pixel_scan_sequencer #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW), .RD_LAT(2), .DST_BASE(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .proc_en(proc_en), .proc_done(proc_done),
    .wren(wren), .wr_addr(wr_addr), .busy(busy), .done(done)
`ifdef PIX_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  pixel_scan_sequencer #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW), .RD_LAT(1), .DST_BASE(131069)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .proc_en(proc_en_b), .proc_done(1'b1),
    .wren(wren_b), .wr_addr(wr_addr_b), .busy(busy_b), .done(done_b)
`ifdef PIX_SEQ_PERF_EN
    , .perf_cycles(perf_cycles_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event log filled by the monitor 1 time unit after each rising edge
  int cyc = 0;
  int nw, nr, ndone, nw_b;
  int wa[16], wt[16], ra[16], rt[16], wa_b[16], wt_b[16];
  int need_p = 0;
  int pcnt = 0;

  initial begin
    proc_done = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (wren) begin
        if (nw < 16) begin wa[nw] = int'(wr_addr); wt[nw] = cyc; end
        nw++;
      end
      if (rd_en) begin
        if (nr < 16) begin ra[nr] = int'(rd_addr); rt[nr] = cyc; end
        nr++;
      end
      if (done) ndone++;
      if (wren_b) begin
        if (nw_b < 16) begin wa_b[nw_b] = int'(wr_addr_b); wt_b[nw_b] = cyc; end
        nw_b++;
      end
      // need_p==0 means proc_done tied high; otherwise raise it on the need_p-th PROC cycle
      if (proc_en) pcnt++;
      else         pcnt = 0;
      proc_done = (need_p == 0) ? 1'b1 : (proc_en && (pcnt == need_p));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    nw = 0; nr = 0; ndone = 0; nw_b = 0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin
      step();
      k++;
    end
  endtask

  int t0;

  initial begin
    reset = 1'b0; start = 1'b1; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    clear_logs();

    // 1. reset with start held high
    step(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_proc_en", proc_en, 0);
    check_eq("rst_wren", wren, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
`ifdef PIX_SEQ_PERF_EN
    check_eq("rst_perf", perf_cycles, 0);
`endif
    @(negedge clk) reset = 1'b1;
    step();
    check_eq("rst_first_read", rd_en, 1);
    check_eq("rst_first_busy", busy, 1);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_in_read", busy, 0);

    // start and abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1;
    step();
    check_eq("idle_start_abort", busy, 0);
    start = 1'b0; abort = 1'b0;

    // 2. full frame, proc_done on 3rd PROC cycle
    need_p = 3;
    clear_logs();
    start = 1'b1; step(); t0 = cyc; start = 1'b0;
    check_eq("f2_read0", rd_en, 1);
    wait_done(200);
    check_eq("f2_done_seen", done, 1);
    // READ is busy cycle 1 at t0, so FINISH (cycle 57) is observed at t0+56
    check_eq("f2_done_time", cyc - t0, 56);
    step(3);
    check_eq("f2_done_count", ndone, 1);
    check_eq("f2_wr_count", nw, 8);
    check_eq("f2_first_wr_time", wt[0] - t0, 6);
    for (int i = 0; i < 8; i++) check_eq($sformatf("f2_wr_addr%0d", i), wa[i], i);
    for (int i = 1; i < 8; i++) check_eq($sformatf("f2_wr_gap%0d", i), wt[i] - wt[i-1], 7);
    check_eq("f2_idle", busy, 0);
`ifdef PIX_SEQ_PERF_EN
    check_eq("f2_perf", perf_cycles, 57);
`endif

    // 3. proc_done tied high
    need_p = 0;
    clear_logs();
    start = 1'b1; step(); t0 = cyc; start = 1'b0;
    wait_done(200);
    check_eq("f3_done_time", cyc - t0, 40);
    step(2);
    check_eq("f3_rd_count", nr, 8);
    check_eq("f3_wr_count", nw, 8);
    check_eq("f3_rd_time0", rt[0] - t0, 0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("f3_rd_addr%0d", i), ra[i], i);
    for (int i = 1; i < 8; i++) check_eq($sformatf("f3_rd_gap%0d", i), rt[i] - rt[i-1], 5);

    // 4. abort during 3rd pixel's WAIT (READ at t0+10, WAIT at t0+11..12)
    clear_logs();
    start = 1'b1; step(); t0 = cyc; start = 1'b0;
    step(11);
    check_eq("f4_in_wait", busy & ~rd_en & ~proc_en & ~wren, 1);
    abort = 1'b1; step(); abort = 1'b0;
    check_eq("f4_abort_idle", busy, 0);
    step(40);
    check_eq("f4_wr_count", nw, 2);
    check_eq("f4_no_done", ndone, 0);
    clear_logs();
    start = 1'b1; step(); start = 1'b0;
    check_eq("f4_restart_rd_en", rd_en, 1);
    check_eq("f4_restart_addr", rd_addr, 0);
    wait_done(200);
    check_eq("f4_restart_done", done, 1);
    step();

    // 5. start pulse mid-frame ignored; start held across FINISH
    clear_logs();
    start = 1'b1; step(); t0 = cyc; start = 1'b0;
    step(6);
    start = 1'b1; step(); start = 1'b0;
    step(27);
    start = 1'b1;
    wait_done(200);
    check_eq("f5_done_time", cyc - t0, 40);
    step();
    check_eq("f5_idle_after_done", busy, 0);
    step();
    check_eq("f5_second_read", rd_en, 1);
    check_eq("f5_second_addr", rd_addr, 0);
    start = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    check_eq("f5_abort_idle", busy, 0);

    // 6. RD_LAT=1, destination base wraps
    clear_logs();
    start_b = 1'b1; step(); t0 = cyc; start_b = 1'b0;
    begin
      int k = 0;
      while (!done_b && k < 200) begin step(); k++; end
    end
    check_eq("f6_done_seen", done_b, 1);
    check_eq("f6_done_time", cyc - t0, 32);
    step(2);
    check_eq("f6_wr_count", nw_b, 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("f6_wr_addr%0d", i), wa_b[i], (131069 + i) % 131072);
    for (int i = 1; i < 8; i++)
      check_eq($sformatf("f6_wr_gap%0d", i), wt_b[i] - wt_b[i-1], 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
